// File: rtl/fifo_bus_arbiter.sv
// Two-master round-robin arbiter in front of the fifo_if register bus.
// Provides an optional bus lock with idle timeout and a sticky irq flag per master.
module fifo_bus_arbiter #(
   parameter int unsigned LOCK_TMO = 16
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       m0_req_i,
   input  logic       m0_lock_i,
   input  logic       m0_rd_i,
   input  logic [1:0] m0_addr_i,
   input  logic [7:0] m0_wrdata_i,
   output logic       m0_ack_o,
   output logic [7:0] m0_rddata_o,
   output logic       m0_irq_o,
   input  logic       m1_req_i,
   input  logic       m1_lock_i,
   input  logic       m1_rd_i,
   input  logic [1:0] m1_addr_i,
   input  logic [7:0] m1_wrdata_i,
   output logic       m1_ack_o,
   output logic [7:0] m1_rddata_o,
   output logic       m1_irq_o,
   output logic       fifo_sel_o,
   output logic       fifo_read_o,
   output logic       fifo_write_o,
   output logic [1:0] fifo_addr_o,
   output logic [7:0] fifo_data_o,
   input  logic [7:0] fifo_data_i,
   input  logic       fifo_in_irq_i,
   input  logic       fifo_out_irq_i,
   output logic       owner_o
);

   // state    | meaning
   // ST_IDLE  | arbitrate between pending requests
   // ST_ISSUE | drive the latched command onto fifo_if for one cycle
   // ST_RESP  | fifo_if returns read data
   // ST_DONE  | ack the owner, update lock
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP, ST_DONE} state_t;

   localparam logic [7:0] TMO_LAST = (LOCK_TMO == 0) ? 8'd0 : 8'(LOCK_TMO - 1);

   state_t      state_q, state_d;
   logic        owner_q, last_q, lock_q, rd_q;
   logic [1:0]  addr_q;
   logic [7:0]  wdata_q, rddata0_q, rddata1_q, tmo_q;
   logic [1:0]  irq_q, irq_clr;
   logic [1:0]  req_vec;
   logic        grant, winner, owner_idle, tmo_hit, irq_set;

   assign req_vec = {m1_req_i, m0_req_i};

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      winner  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (lock_q) begin
               grant  = req_vec[owner_q];
               winner = owner_q;
            end else if (&req_vec) begin
               grant  = 1'b1;
               winner = ~last_q;
            end else if (|req_vec) begin
               grant  = 1'b1;
               winner = m1_req_i;
            end
            if (grant) state_d = ST_ISSUE;
         end
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Lock owner is always owner_q: while locked only the owner can be granted.
   assign owner_idle = lock_q && (state_q == ST_IDLE) && !req_vec[owner_q];
   assign tmo_hit    = (LOCK_TMO != 0) && owner_idle && (tmo_q == TMO_LAST);
   assign irq_set    = fifo_in_irq_i | fifo_out_irq_i;

   always_comb begin
      irq_clr = 2'b00;
      if (state_q == ST_DONE && rd_q && (addr_q == 2'b01 || addr_q == 2'b10))
         irq_clr[owner_q] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= ST_IDLE;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         lock_q    <= 1'b0;
         rd_q      <= 1'b0;
         addr_q    <= 2'b00;
         wdata_q   <= 8'h00;
         rddata0_q <= 8'h00;
         rddata1_q <= 8'h00;
         tmo_q     <= 8'h00;
         irq_q     <= 2'b00;
      end else begin
         state_q <= state_d;
         if (grant) begin
            owner_q <= winner;
            last_q  <= winner;
            rd_q    <= winner ? m1_rd_i     : m0_rd_i;
            addr_q  <= winner ? m1_addr_i   : m0_addr_i;
            wdata_q <= winner ? m1_wrdata_i : m0_wrdata_i;
         end
         if (state_q == ST_RESP && rd_q) begin
            if (owner_q) rddata1_q <= fifo_data_i;
            else         rddata0_q <= fifo_data_i;
         end
         if (state_q == ST_DONE)
            lock_q <= owner_q ? m1_lock_i : m0_lock_i;
         else if (tmo_hit)
            lock_q <= 1'b0;
         if (!lock_q || grant || tmo_hit)
            tmo_q <= 8'h00;
         else if (owner_idle && tmo_q != 8'hff)
            tmo_q <= tmo_q + 8'h01;
         irq_q <= (irq_q & ~irq_clr) | {2{irq_set}};
      end
   end

   assign fifo_sel_o   = (state_q == ST_ISSUE);
   assign fifo_read_o  = fifo_sel_o & rd_q;
   assign fifo_write_o = fifo_sel_o & ~rd_q;
   assign fifo_addr_o  = fifo_sel_o ? addr_q  : 2'b00;
   assign fifo_data_o  = fifo_sel_o ? wdata_q : 8'h00;
   assign m0_ack_o     = (state_q == ST_DONE) & ~owner_q;
   assign m1_ack_o     = (state_q == ST_DONE) &  owner_q;
   assign m0_rddata_o  = rddata0_q;
   assign m1_rddata_o  = rddata1_q;
   assign m0_irq_o     = irq_q[0];
   assign m1_irq_o     = irq_q[1];
   assign owner_o      = owner_q;

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// Bench for fifo_bus_arbiter: fake fifo_if register slave, vector table,
// directed lock/irq/reset sequences and a randomized two-master run.
module tb_fifo_bus_arbiter;
   localparam int TMO = 16;

   logic       clk = 1'b0;
   logic       rstn;
   logic [1:0] req, lock, rd;
   logic [1:0] addr [2];
   logic [7:0] wd [2];
   logic       ack0, ack1, irq0, irq1, owner;
   logic [1:0] ack, irq;
   logic [7:0] rdd0, rdd1;
   logic       f_sel, f_read, f_write, in_irq, out_irq;
   logic [1:0] f_addr;
   logic [7:0] f_wdata, f_rdata;

   logic [7:0] slv_mem [4];
   logic [7:0] ref_mem [4];
   logic [7:0] wq [$];
   int checks = 0, failures = 0;

   assign ack = {ack1, ack0};
   assign irq = {irq1, irq0};

   always #5 clk = ~clk;

   fifo_bus_arbiter #(.LOCK_TMO(TMO)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .m0_req_i(req[0]), .m0_lock_i(lock[0]), .m0_rd_i(rd[0]), .m0_addr_i(addr[0]),
      .m0_wrdata_i(wd[0]), .m0_ack_o(ack0), .m0_rddata_o(rdd0), .m0_irq_o(irq0),
      .m1_req_i(req[1]), .m1_lock_i(lock[1]), .m1_rd_i(rd[1]), .m1_addr_i(addr[1]),
      .m1_wrdata_i(wd[1]), .m1_ack_o(ack1), .m1_rddata_o(rdd1), .m1_irq_o(irq1),
      .fifo_sel_o(f_sel), .fifo_read_o(f_read), .fifo_write_o(f_write),
      .fifo_addr_o(f_addr), .fifo_data_o(f_wdata), .fifo_data_i(f_rdata),
      .fifo_in_irq_i(in_irq), .fifo_out_irq_i(out_irq), .owner_o(owner)
   );

   // Register slave with one-cycle read latency.
   always @(posedge clk) begin
      if (f_sel && f_write) slv_mem[f_addr] <= f_wdata;
      if (f_sel && f_read)  f_rdata <= slv_mem[f_addr];
   end

   always @(negedge clk) if (f_write) wq.push_back(f_wdata);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rdd_of(input int m);
      return (m == 0) ? rdd0 : rdd1;
   endfunction

   // One command on an otherwise idle bus; returns at the negedge of the ack cycle.
   task automatic single_cmd(input int m, input logic r, input logic [1:0] a, input logic [7:0] d,
                             input logic lk, input int exp_lat, input string nm);
      int  k;
      bit  done;
      @(posedge clk); #1;
      rd[m] = r; addr[m] = a; wd[m] = d; lock[m] = lk; req[m] = 1'b1;
      k = 0; done = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         if (k == 1 && exp_lat > 0)
            chk({nm, "_strobe"}, 32'({f_sel, f_read, f_write, f_addr, (r ? 8'h00 : f_wdata)}),
                32'({1'b1, r, ~r, a, (r ? 8'h00 : d)}));
         if (ack[m]) done = 1;
         else k++;
      end
      req[m] = 1'b0;
      if (!done) chk({nm, "_timeout"}, 32'(0), 32'(1));
      else if (exp_lat > 0) chk({nm, "_lat"}, 32'(k), 32'(exp_lat));
   endtask

   task automatic wait_ack(input int m, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[m] && n < 60);
   endtask

   task automatic rnd_master(input int m, input int ncmd);
      int  gap, n;
      bit  got;
      for (int i = 0; i < ncmd; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) @(posedge clk);
         @(posedge clk); #1;
         rd[m] = 1'($urandom_range(0, 1));
         addr[m] = 2'($urandom_range(0, 3));
         wd[m] = 8'($urandom);
         req[m] = 1'b1;
         n = 0; got = 0;
         while (!got && n < 20) begin
            @(negedge clk);
            if (ack[m]) got = 1;
            else n++;
         end
         req[m] = 1'b0;
         chk("rnd_lat_bound", 32'(got && n >= 3 && n <= 7), 32'(1));
         if (got) begin
            chk("rnd_owner", 32'(owner), 32'(m));
            if (rd[m]) chk("rnd_rddata", 32'(rdd_of(m)), 32'(ref_mem[addr[m]]));
            else ref_mem[addr[m]] = wd[m];
         end
      end
   endtask

   typedef struct {
      int         m;
      logic       r;
      logic [1:0] a;
      logic [7:0] d;
      logic [7:0] exp_rd;
   } vec_t;

   typedef struct {
      int         m;
      logic       r;
      logic [1:0] a;
      logic [1:0] exp_irq;
   } irq_vec_t;

   initial begin
      vec_t     tbl [8];
      irq_vec_t itbl [4];
      int       t0, t1, n, cnt;

      for (int i = 0; i < 4; i++) begin slv_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
      f_rdata = 8'h00;
      rstn = 1'b0; req = 2'b00; lock = 2'b00; rd = 2'b00; in_irq = 1'b0; out_irq = 1'b0;
      for (int i = 0; i < 2; i++) begin addr[i] = 2'b00; wd[i] = 8'h00; end

      repeat (3) @(negedge clk);
      chk("rst_bus", 32'({f_sel, f_read, f_write, f_addr, f_wdata}), 32'(0));
      chk("rst_ack", 32'(ack), 32'(0));
      chk("rst_rdd", 32'({rdd1, rdd0}), 32'(0));
      chk("rst_irq_owner", 32'({irq, owner}), 32'(0));
      rstn = 1'b1;

      // Simultaneous requests straight out of reset: m0 wins the first tie.
      wq.delete();
      @(posedge clk); #1;
      rd = 2'b00; addr[0] = 2'd0; addr[1] = 2'd0; wd[0] = 8'h41; wd[1] = 8'h42; req = 2'b11;
      t0 = -1; t1 = -1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (ack[0] && t0 < 0) begin t0 = k; req[0] = 1'b0; end
         if (ack[1] && t1 < 0) begin t1 = k; req[1] = 1'b0; end
      end
      req = 2'b00;
      chk("tie_ack0_time", 32'(t0), 32'(3));
      chk("tie_ack1_time", 32'(t1), 32'(7));
      chk("tie_wr_count", 32'(wq.size()), 32'(2));
      if (wq.size() == 2) chk("tie_wr_order", 32'({wq[0], wq[1]}), 32'(16'h4142));

      tbl[0] = '{0, 1'b0, 2'd2, 8'h01, 8'h00};
      tbl[1] = '{0, 1'b1, 2'd2, 8'h00, 8'h01};
      tbl[2] = '{1, 1'b0, 2'd1, 8'h22, 8'h00};
      tbl[3] = '{1, 1'b1, 2'd1, 8'h00, 8'h22};
      tbl[4] = '{0, 1'b1, 2'd1, 8'h00, 8'h22};
      tbl[5] = '{1, 1'b0, 2'd3, 8'hA5, 8'h00};
      tbl[6] = '{1, 1'b1, 2'd3, 8'h00, 8'hA5};
      tbl[7] = '{0, 1'b1, 2'd0, 8'h00, 8'h42};
      for (int i = 0; i < 8; i++) begin
         single_cmd(tbl[i].m, tbl[i].r, tbl[i].a, tbl[i].d, 1'b0, 3, "vec");
         if (tbl[i].r) chk("vec_rddata", 32'(rdd_of(tbl[i].m)), 32'(tbl[i].exp_rd));
      end
      chk("rddata_held_m1", 32'(rdd1), 32'(8'hA5));

      // Lock blocks m1 until m0 releases it.
      single_cmd(0, 1'b1, 2'd1, 8'h00, 1'b1, 3, "lock_rd");
      @(posedge clk); #1;
      rd[1] = 1'b0; addr[1] = 2'd3; wd[1] = 8'h5A; lock[1] = 1'b0; req[1] = 1'b1;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin @(negedge clk); if (ack[1]) cnt++; end
      chk("lock_blocks_m1", 32'(cnt), 32'(0));
      single_cmd(0, 1'b0, 2'd1, 8'h33, 1'b0, 3, "lock_wr");
      wait_ack(1, n);
      req[1] = 1'b0;
      chk("unlock_m1_ack", 32'(n), 32'(4));

      // Lock held by an idle owner is released by the timeout.
      single_cmd(0, 1'b0, 2'd2, 8'h77, 1'b1, 3, "tmo_wr");
      rd[1] = 1'b1; addr[1] = 2'd2; lock[1] = 1'b0; req[1] = 1'b1;
      wait_ack(1, n);
      req[1] = 1'b0;
      chk("tmo_m1_ack", 32'(n), 32'(TMO + 4));
      chk("tmo_m1_rddata", 32'(rdd1), 32'(8'h77));
      lock[0] = 1'b0;

      // IRQ flags: set wins over a same-cycle status-read clear.
      @(posedge clk); #1 in_irq = 1'b1;
      @(posedge clk); #1 in_irq = 1'b0;
      @(negedge clk);
      chk("irq_set_both", 32'(irq), 32'(2'b11));
      @(posedge clk); #1;
      rd[0] = 1'b1; addr[0] = 2'd2; req[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_irq = 1'b1;
      @(negedge clk);
      chk("irq_done_ack", 32'(ack[0]), 32'(1));
      req[0] = 1'b0;
      @(posedge clk); #1 out_irq = 1'b0;
      @(negedge clk);
      chk("irq_set_wins", 32'(irq), 32'(2'b11));

      itbl[0] = '{0, 1'b1, 2'd1, 2'b10};
      itbl[1] = '{1, 1'b1, 2'd0, 2'b10};
      itbl[2] = '{1, 1'b0, 2'd1, 2'b10};
      itbl[3] = '{1, 1'b1, 2'd2, 2'b00};
      for (int i = 0; i < 4; i++) begin
         single_cmd(itbl[i].m, itbl[i].r, itbl[i].a, 8'h00, 1'b0, 3, "irq_cmd");
         @(negedge clk);
         chk("irq_clear", 32'(irq), 32'(itbl[i].exp_irq));
      end

      // Randomized two-master traffic against a reference register image.
      for (int i = 0; i < 4; i++) begin
         ref_mem[i] = 8'($urandom);
         single_cmd(0, 1'b0, 2'(i), ref_mem[i], 1'b0, 3, "seed");
      end
      fork
         rnd_master(0, 30);
         rnd_master(1, 30);
      join

      // Reset during ST_RESP abandons the command.
      @(posedge clk); #1 in_irq = 1'b1;
      @(posedge clk); #1;
      in_irq = 1'b0;
      rd[0] = 1'b1; addr[0] = 2'd3; req[0] = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mid_issue", 32'(f_read), 32'(1));
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("rst_mid_outputs", 32'({f_sel, f_read, f_write, ack}), 32'(0));
      chk("rst_mid_state", 32'({rdd0, irq, owner}), 32'(0));
      req[0] = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin @(negedge clk); if (|ack) cnt++; end
      chk("rst_mid_no_ack", 32'(cnt), 32'(0));
      single_cmd(0, 1'b1, 2'd3, 8'h00, 1'b0, 3, "post_rst");
      chk("post_rst_rddata", 32'(rdd0), 32'(ref_mem[3]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "global timeout");
   end
endmodule
